fp32_booth4_multiplier: RTL

- Iterative IEEE-754 single-precision multiplier. It is the inverse-operation companion to the FP32 SRT radix-4 divider and shares its datapath style.
- The 24-bit significand product uses radix-4 Booth recoding (digit set {-2,-1,0,+1,+2}, two multiplier bits per cycle). It accumulates into a carry-propagate register, then does a normalize/round/pack stage.
- Sits beside the divider in the FP arithmetic cluster, with a start/done handshake.

---
 rtl/fp32_booth4_multiplier.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/fp32_booth4_multiplier.sv
// Purpose: iterative FP32 multiplier, radix-4 Booth significand product, RNE rounding, FTZ.
// Latency: fixed 15 cycles from accepted start to the done pulse, special operands included.
// Backpressure: none; start is taken only in IDLE and ignored while busy or while done is high.
module fp32_booth4_multiplier #(
    parameter logic [31:0] QNAN = 32'h7FC0_0000,
    parameter bit          FTZ  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] product,
    output logic [2:0]  flags
);

    typedef enum logic [1:0] {IDLE, UNPACK, ITER, ROUND} state_t;

    state_t             state;
    logic [31:0]        a_r;
    logic [31:0]        b_r;
    logic               sgn;
    logic [23:0]        ma;
    logic [25:0]        mb_sh;
    logic               mb_prev;
    logic signed [9:0]  exp_sum;
    logic [47:0]        acc;
    logic [3:0]         cnt;
    logic               special;
    logic [31:0]        spec_res;
    logic [2:0]         spec_flg;

    // operand classification, evaluated on the captured operands during UNPACK
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic        u_sgn;
    logic        u_special;
    logic [31:0] u_res;
    logic [2:0]  u_flg;

    // Classify operands and choose the preset result for special cases
    always_comb begin
        u_sgn     = a_r[31] ^ b_r[31];
        a_zero    = (a_r[30:23] == 8'h00) && (FTZ || a_r[22:0] == 23'd0);
        b_zero    = (b_r[30:23] == 8'h00) && (FTZ || b_r[22:0] == 23'd0);
        a_inf     = (a_r[30:23] == 8'hFF) && (a_r[22:0] == 23'd0);
        b_inf     = (b_r[30:23] == 8'hFF) && (b_r[22:0] == 23'd0);
        a_nan     = (a_r[30:23] == 8'hFF) && (a_r[22:0] != 23'd0);
        b_nan     = (b_r[30:23] == 8'hFF) && (b_r[22:0] != 23'd0);
        u_special = 1'b0;
        u_res     = 32'd0;
        u_flg     = 3'b000;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            u_special = 1'b1;
            u_res     = QNAN;
            u_flg     = 3'b100;
        end else if (a_inf || b_inf) begin
            u_special = 1'b1;
            u_res     = {u_sgn, 8'hFF, 23'd0};
        end else if (a_zero || b_zero) begin
            u_special = 1'b1;
            u_res     = {u_sgn, 31'd0};
        end
    end

    // Booth digit recoding and the shifted partial product for this iteration.
    // The exact product fits in 48 bits, so two's-complement partial products are
    // kept at 48 bits; the upper bits of a wider sign extension would always cancel.
    logic [2:0]  trip;
    logic [47:0] mag;
    logic [47:0] pp;
    logic [47:0] pp_sh;
    logic        neg;
    always_comb begin
        trip = {mb_sh[1:0], mb_prev};
        neg  = 1'b0;
        mag  = 48'd0;
        case (trip)
            3'b001, 3'b010: mag = {24'd0, ma};
            3'b011:         mag = {23'd0, ma, 1'b0};
            3'b100: begin
                mag = {23'd0, ma, 1'b0};
                neg = 1'b1;
            end
            3'b101, 3'b110: begin
                mag = {24'd0, ma};
                neg = 1'b1;
            end
            default:        mag = 48'd0;
        endcase
        pp    = neg ? (~mag + 48'd1) : mag;
        pp_sh = pp << {cnt, 1'b0};
    end

    // Normalize, round to nearest even, and detect exponent overflow/underflow
    logic [23:0]       keep;
    logic              g_bit;
    logic              s_bit;
    logic              rnd;
    logic [24:0]       sum25;
    logic [22:0]       frac;
    logic signed [9:0] e1;
    logic signed [9:0] e2;
    logic [31:0]       r_res;
    logic [2:0]        r_flg;
    always_comb begin
        if (acc[47]) begin
            keep  = acc[47:24];
            g_bit = acc[23];
            s_bit = |acc[22:0];
            e1    = exp_sum + 10'sd1;
        end else begin
            keep  = acc[46:23];
            g_bit = acc[22];
            s_bit = |acc[21:0];
            e1    = exp_sum;
        end
        rnd   = g_bit & (s_bit | keep[0]);
        sum25 = {1'b0, keep} + {24'd0, rnd};
        // a carry out of the rounded mantissa leaves 1.000..0, one binade up
        frac  = sum25[24] ? sum25[23:1] : sum25[22:0];
        e2    = sum25[24] ? (e1 + 10'sd1) : e1;
        if (e2 >= 10'sd255) begin
            r_res = {sgn, 8'hFF, 23'd0};
            r_flg = 3'b010;
        end else if (e2 <= 10'sd0) begin
            r_res = {sgn, 31'd0};
            r_flg = 3'b001;
        end else begin
            r_res = {sgn, e2[7:0], frac};
            r_flg = 3'b000;
        end
    end

    // Control FSM and datapath registers; busy covers the iteration and rounding cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            a_r      <= 32'd0;
            b_r      <= 32'd0;
            sgn      <= 1'b0;
            ma       <= 24'd0;
            mb_sh    <= 26'd0;
            mb_prev  <= 1'b0;
            exp_sum  <= 10'sd0;
            acc      <= 48'd0;
            cnt      <= 4'd0;
            special  <= 1'b0;
            spec_res <= 32'd0;
            spec_flg <= 3'b000;
            busy     <= 1'b0;
            done     <= 1'b0;
            product  <= 32'd0;
            flags    <= 3'b000;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // the done cycle is still IDLE, but a start seen there is dropped
                    if (start && !done) begin
                        a_r   <= a;
                        b_r   <= b;
                        state <= UNPACK;
                    end
                end
                UNPACK: begin
                    sgn      <= u_sgn;
                    ma       <= {1'b1, a_r[22:0]};
                    mb_sh    <= {2'b00, 1'b1, b_r[22:0]};
                    mb_prev  <= 1'b0;
                    exp_sum  <= {2'b00, a_r[30:23]} + {2'b00, b_r[30:23]} - 10'd127;
                    special  <= u_special;
                    spec_res <= u_res;
                    spec_flg <= u_flg;
                    acc      <= 48'd0;
                    cnt      <= 4'd0;
                    busy     <= 1'b1;
                    state    <= ITER;
                end
                ITER: begin
                    // specials also run the 13 steps so latency stays fixed
                    acc     <= acc + pp_sh;
                    mb_prev <= mb_sh[1];
                    mb_sh   <= {2'b00, mb_sh[25:2]};
                    cnt     <= cnt + 4'd1;
                    if (cnt == 4'd12) begin
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    product <= special ? spec_res : r_res;
                    flags   <= special ? spec_flg : r_flg;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
